// File: rtl/execute_unit.sv
// Execute stage: operand select/forwarding, single-cycle ALU, branch resolution and an
// iterative shift-add multiplier that stalls the unit for WIDTH cycles.
module execute_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [WIDTH-1:0] inport,
  input  logic [WIDTH-1:0] immediate,
  input  logic [WIDTH-1:0] shamt,
  input  logic [WIDTH-1:0] fwd_exmem,
  input  logic [WIDTH-1:0] fwd_memwb,
  input  logic [4:0]       alu_op,
  input  logic [1:0]       alu_src,
  input  logic [1:0]       fwd1_sel,
  input  logic [1:0]       fwd2_sel,
  input  logic             inport_en,
  input  logic             branch,
  input  logic [1:0]       jmp_cond,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] mem_addr,
  output logic [2:0]       ccr,
  output logic             br_taken,
  output logic [WIDTH-1:0] br_target
);

  localparam logic [4:0] OpNop  = 5'h00;
  localparam logic [4:0] OpMov  = 5'h01;
  localparam logic [4:0] OpAdd  = 5'h02;
  localparam logic [4:0] OpSub  = 5'h03;
  localparam logic [4:0] OpAnd  = 5'h04;
  localparam logic [4:0] OpOr   = 5'h05;
  localparam logic [4:0] OpNot  = 5'h06;
  localparam logic [4:0] OpInc  = 5'h07;
  localparam logic [4:0] OpDec  = 5'h08;
  localparam logic [4:0] OpShl  = 5'h09;
  localparam logic [4:0] OpShr  = 5'h0A;
  localparam logic [4:0] OpSetc = 5'h0B;
  localparam logic [4:0] OpClrc = 5'h0C;
  localparam logic [4:0] OpMul  = 5'h0D;

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StMulBusy} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  result_q, mem_addr_q, br_target_q;
  logic [2:0]        ccr_q;
  logic              out_valid_q, br_taken_q;
  logic [WIDTH-1:0]  acc_q, mcand_q, mplier_q;
  logic [CntW-1:0]   cnt_q;

  logic [WIDTH-1:0]  a_base, a_opnd, bf_opnd, b_opnd;
  logic [SHW-1:0]    sh_amt;
  logic [WIDTH:0]    add_full, inc_full, shl_full, shr_full;
  logic [WIDTH-1:0]  alu_res, acc_nxt;
  logic              c_flag, upd_zn, cond_met, br_take, accept, start_mul;
  logic [2:0]        alu_flags, sc_flags;

  assign in_ready = (state_q == StIdle);

  // Operand selection: inport override, then forwarding; B picks forwarded op2 or an immediate.
  always_comb begin
    a_base = inport_en ? inport : op1;
    case (fwd1_sel)
      2'd1:    a_opnd = fwd_exmem;
      2'd2:    a_opnd = fwd_memwb;
      default: a_opnd = a_base;
    endcase
    case (fwd2_sel)
      2'd1:    bf_opnd = fwd_exmem;
      2'd2:    bf_opnd = fwd_memwb;
      default: bf_opnd = op2;
    endcase
    case (alu_src)
      2'd0:    b_opnd = bf_opnd;
      2'd2:    b_opnd = shamt;
      default: b_opnd = immediate;
    endcase
  end

  assign sh_amt   = b_opnd[SHW-1:0];
  assign add_full = {1'b0, a_opnd} + {1'b0, b_opnd};
  assign inc_full = {1'b0, a_opnd} + {{WIDTH{1'b0}}, 1'b1};
  // The extra bit on each shift captures the last bit pushed out.
  assign shl_full = {1'b0, a_opnd} << sh_amt;
  assign shr_full = {a_opnd, 1'b0} >> sh_amt;

  always_comb begin
    alu_res = result_q;
    c_flag  = ccr_q[2];
    upd_zn  = 1'b0;
    case (alu_op)
      OpMov: begin alu_res = a_opnd; upd_zn = 1'b1; end
      OpAdd: begin alu_res = add_full[WIDTH-1:0]; c_flag = add_full[WIDTH]; upd_zn = 1'b1; end
      OpSub: begin alu_res = a_opnd - b_opnd; c_flag = (a_opnd < b_opnd); upd_zn = 1'b1; end
      OpAnd: begin alu_res = a_opnd & b_opnd; upd_zn = 1'b1; end
      OpOr:  begin alu_res = a_opnd | b_opnd; upd_zn = 1'b1; end
      OpNot: begin alu_res = ~a_opnd; upd_zn = 1'b1; end
      OpInc: begin alu_res = inc_full[WIDTH-1:0]; c_flag = inc_full[WIDTH]; upd_zn = 1'b1; end
      OpDec: begin
        alu_res = a_opnd - {{(WIDTH-1){1'b0}}, 1'b1};
        c_flag  = (a_opnd == '0);
        upd_zn  = 1'b1;
      end
      OpShl: begin
        alu_res = shl_full[WIDTH-1:0];
        if (sh_amt != '0) c_flag = shl_full[WIDTH];
        upd_zn = 1'b1;
      end
      OpShr: begin
        alu_res = shr_full[WIDTH:1];
        if (sh_amt != '0) c_flag = shr_full[0];
        upd_zn = 1'b1;
      end
      OpSetc: c_flag = 1'b1;
      OpClrc: c_flag = 1'b0;
      OpNop:  ;
      default: ;
    endcase
  end

  assign alu_flags = {c_flag,
                      upd_zn ? alu_res[WIDTH-1] : ccr_q[1],
                      upd_zn ? (alu_res == '0)  : ccr_q[0]};

  // Conditions test the flags held before this instruction; a taken conditional consumes its flag.
  always_comb begin
    case (jmp_cond)
      2'd1:    cond_met = ccr_q[0];
      2'd2:    cond_met = ccr_q[1];
      2'd3:    cond_met = ccr_q[2];
      default: cond_met = 1'b1;
    endcase
    br_take  = branch & cond_met;
    sc_flags = alu_flags;
    if (br_take) begin
      case (jmp_cond)
        2'd1:    sc_flags[0] = 1'b0;
        2'd2:    sc_flags[1] = 1'b0;
        2'd3:    sc_flags[2] = 1'b0;
        default: ;
      endcase
    end
  end

  assign accept    = in_valid & in_ready & ~flush;
  // A branch never starts the multiplier; MUL on a branch slot acts as a NOP.
  assign start_mul = accept & (alu_op == OpMul) & ~branch;
  assign acc_nxt   = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      result_q    <= '0;
      mem_addr_q  <= '0;
      br_target_q <= '0;
      ccr_q       <= '0;
      out_valid_q <= 1'b0;
      br_taken_q  <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= 1'b0;
      br_taken_q  <= 1'b0;
      if (flush) begin
        state_q <= StIdle;
      end else begin
        case (state_q)
          StIdle: begin
            if (start_mul) begin
              acc_q    <= '0;
              mcand_q  <= a_opnd;
              mplier_q <= b_opnd;
              cnt_q    <= '0;
              state_q  <= StMulBusy;
            end else if (accept) begin
              result_q    <= alu_res;
              mem_addr_q  <= branch ? a_opnd : bf_opnd;
              ccr_q       <= sc_flags;
              out_valid_q <= 1'b1;
              if (br_take) begin
                br_taken_q  <= 1'b1;
                br_target_q <= a_opnd;
              end
            end
          end
          StMulBusy: begin
            acc_q    <= acc_nxt;
            mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
            cnt_q    <= cnt_q + CntW'(1);
            if (cnt_q == CntLast) begin
              result_q    <= acc_nxt;
              ccr_q       <= {ccr_q[2], acc_nxt[WIDTH-1], (acc_nxt == '0)};
              out_valid_q <= 1'b1;
              state_q     <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign mem_addr  = mem_addr_q;
  assign ccr       = ccr_q;
  assign br_taken  = br_taken_q;
  assign br_target = br_target_q;

endmodule

// File: tb/tb_execute_unit.sv
// Directed and randomized checks of execute_unit against an arithmetic reference model.
module tb_execute_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, in_ready, flush;
  logic [15:0] op1, op2, inport, immediate, shamt, fwd_exmem, fwd_memwb;
  logic [4:0]  alu_op;
  logic [1:0]  alu_src, fwd1_sel, fwd2_sel, jmp_cond;
  logic        inport_en, branch;
  logic        out_valid, br_taken;
  logic [15:0] result, mem_addr, br_target;
  logic [2:0]  ccr;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_result = '0, m_mem = '0, m_target = '0;
  logic [2:0]  m_ccr = '0;

  execute_unit #(.WIDTH(16), .SHW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .op1(op1), .op2(op2), .inport(inport), .immediate(immediate), .shamt(shamt),
    .fwd_exmem(fwd_exmem), .fwd_memwb(fwd_memwb), .alu_op(alu_op), .alu_src(alu_src),
    .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .inport_en(inport_en), .branch(branch),
    .jmp_cond(jmp_cond), .out_valid(out_valid), .result(result), .mem_addr(mem_addr),
    .ccr(ccr), .br_taken(br_taken), .br_target(br_target)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 0; flush = 0; op1 = '0; op2 = '0; inport = '0; immediate = '0; shamt = '0;
    fwd_exmem = '0; fwd_memwb = '0; alu_op = '0; alu_src = '0; fwd1_sel = '0;
    fwd2_sel = '0; inport_en = 0; branch = 0; jmp_cond = '0;
  endtask

  function automatic logic [15:0] pick(input logic [1:0] sel, input logic [15:0] base);
    if (sel == 2'd1) return fwd_exmem;
    if (sel == 2'd2) return fwd_memwb;
    return base;
  endfunction

  function automatic logic [15:0] opnd_a();
    return pick(fwd1_sel, inport_en ? inport : op1);
  endfunction

  function automatic logic [15:0] opnd_b();
    if (alu_src == 2'd0) return pick(fwd2_sel, op2);
    if (alu_src == 2'd2) return shamt;
    return immediate;
  endfunction

  // Reference ALU in plain integer arithmetic.
  task automatic ref_alu(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] f_in, output logic [15:0] r,
                         output logic [2:0] f_out, output bit has_res);
    longint unsigned ia, ib, full;
    int unsigned amt;
    bit c, zn;
    ia = longint'(a); ib = longint'(b); amt = int'(b) % 16;
    c = f_in[2]; zn = 1; has_res = 1; r = '0; full = 0;
    case (op)
      5'h01: r = a;
      5'h02: begin full = ia + ib; r = 16'(full % 65536); c = (full > 65535); end
      5'h03: begin full = ia + 65536 - ib; r = 16'(full % 65536); c = (ia < ib); end
      5'h04: r = a & b;
      5'h05: r = a | b;
      5'h06: r = ~a;
      5'h07: begin full = ia + 1; r = 16'(full % 65536); c = (ia == 65535); end
      5'h08: begin full = ia + 65535; r = 16'(full % 65536); c = (ia == 0); end
      5'h09: begin
        full = ia * (64'd1 << amt);
        r = 16'(full % 65536);
        if (amt != 0) c = ((full / 65536) % 2) == 1;
      end
      5'h0A: begin
        r = 16'(ia / (64'd1 << amt));
        if (amt != 0) c = ((ia / (64'd1 << (amt - 1))) % 2) == 1;
      end
      5'h0B: begin c = 1; zn = 0; has_res = 0; end
      5'h0C: begin c = 0; zn = 0; has_res = 0; end
      default: begin zn = 0; has_res = 0; end
    endcase
    f_out = {c, zn ? r[15] : f_in[1], zn ? (r == 16'h0) : f_in[0]};
  endtask

  // Issue the currently driven single-cycle instruction and check the registered outcome.
  task automatic run_sc(input string tag);
    logic [15:0] a_e, b_e, r;
    logic [2:0] f;
    bit has_res, cond, taken;
    a_e = opnd_a();
    b_e = opnd_b();
    ref_alu(alu_op, a_e, b_e, m_ccr, r, f, has_res);
    case (jmp_cond)
      2'd1: cond = m_ccr[0];
      2'd2: cond = m_ccr[1];
      2'd3: cond = m_ccr[2];
      default: cond = 1;
    endcase
    taken = branch && cond;
    if (taken) begin
      m_target = a_e;
      if (jmp_cond == 2'd1) f[0] = 0;
      if (jmp_cond == 2'd2) f[1] = 0;
      if (jmp_cond == 2'd3) f[2] = 0;
    end
    if (has_res) m_result = r;
    m_mem = branch ? a_e : pick(fwd2_sel, op2);
    m_ccr = f;
    in_valid = 1;
    tick();
    in_valid = 0; branch = 0;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(1));
    chk({tag, ".result"}, 32'(result), 32'(m_result));
    chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(m_mem));
    chk({tag, ".ccr"}, 32'(ccr), 32'(m_ccr));
    chk({tag, ".br_taken"}, 32'(br_taken), 32'(taken));
    chk({tag, ".br_target"}, 32'(br_target), 32'(m_target));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(1));
  endtask

  task automatic run_mul(input string tag);
    logic [15:0] p;
    p = 16'((longint'(opnd_a()) * longint'(opnd_b())) % 65536);
    alu_op = 5'h0D; branch = 0; in_valid = 1;
    tick();
    in_valid = 0;
    for (int i = 0; i < 16; i++) begin
      if (i != 0) tick();
      chk({tag, ".busy_ready"}, 32'(in_ready), 32'(0));
      chk({tag, ".busy_valid"}, 32'(out_valid), 32'(0));
    end
    tick();
    m_result = p;
    m_ccr = {m_ccr[2], p[15], p == 16'h0};
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(1));
    chk({tag, ".result"}, 32'(result), 32'(m_result));
    chk({tag, ".ccr"}, 32'(ccr), 32'(m_ccr));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(1));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".result"}, 32'(result), 32'(0));
    chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(0));
    chk({tag, ".br_target"}, 32'(br_target), 32'(0));
    chk({tag, ".ccr"}, 32'(ccr), 32'(0));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(0));
    chk({tag, ".br_taken"}, 32'(br_taken), 32'(0));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(1));
  endtask

  initial begin
    int seen;
    clear_inputs();
    #1;
    check_all_zero("reset");
    tick();
    check_all_zero("reset_edge");
    @(negedge clk);
    rst = 1;

    // ADD wrap-around sets C and Z.
    op1 = 16'hFFFF; op2 = 16'h0001; alu_op = 5'h02;
    run_sc("add_wrap");
    chk("add_wrap.ccr_const", 32'(ccr), 32'(3'b101));
    tick();
    chk("add_wrap.pulse", 32'(out_valid), 32'(0));
    chk("add_wrap.hold", 32'(result), 32'(16'h0000));

    // Forwarded SUB with immediate, then a borrowing SUB.
    clear_inputs();
    fwd1_sel = 2'd1; fwd_exmem = 16'h0005; alu_src = 2'd1; immediate = 16'h0003; alu_op = 5'h03;
    run_sc("sub_fwd");
    chk("sub_fwd.const", 32'(result), 32'(16'h0002));
    clear_inputs();
    op1 = 16'h0003; alu_src = 2'd1; immediate = 16'h0005; alu_op = 5'h03;
    run_sc("sub_borrow");
    chk("sub_borrow.ccr_const", 32'(ccr), 32'(3'b110));

    // Multiply 0x12 * 0x10.
    clear_inputs();
    op1 = 16'h0012; op2 = 16'h0010;
    run_mul("mul");
    chk("mul.const", 32'(result), 32'(16'h0120));

    // Flush aborts a multiply in progress.
    clear_inputs();
    op1 = 16'h1234; op2 = 16'h0003; alu_op = 5'h0D; in_valid = 1;
    tick();
    in_valid = 0;
    for (int i = 1; i < 5; i++) tick();
    flush = 1;
    tick();
    flush = 0;
    chk("mul_flush.ready", 32'(in_ready), 32'(1));
    chk("mul_flush.valid", 32'(out_valid), 32'(0));
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("mul_flush.no_valid", 32'(seen), 32'(0));
    chk("mul_flush.ccr", 32'(ccr), 32'(m_ccr));
    chk("mul_flush.result", 32'(result), 32'(m_result));

    // Flush beats acceptance in idle.
    clear_inputs();
    op1 = 16'h0101; op2 = 16'h0202; alu_op = 5'h02; in_valid = 1; flush = 1;
    tick();
    clear_inputs();
    chk("flush_idle.valid", 32'(out_valid), 32'(0));
    chk("flush_idle.result", 32'(result), 32'(m_result));

    // Branch on Z: taken then not taken.
    op1 = 16'h0005; op2 = 16'h0005; alu_op = 5'h03;
    run_sc("set_z");
    clear_inputs();
    branch = 1; jmp_cond = 2'd1; op1 = 16'h0040;
    run_sc("br_z_taken");
    chk("br_z_taken.target_const", 32'(br_target), 32'(16'h0040));
    tick();
    chk("br_z_taken.pulse", 32'(br_taken), 32'(0));
    clear_inputs();
    branch = 1; jmp_cond = 2'd1; op1 = 16'h0080;
    run_sc("br_z_not");
    chk("br_z_not.target_const", 32'(br_target), 32'(16'h0040));

    // Randomized instructions against the model.
    for (int n = 0; n < 160; n++) begin
      clear_inputs();
      op1 = 16'($urandom); op2 = 16'($urandom); inport = 16'($urandom);
      immediate = 16'($urandom); shamt = 16'($urandom_range(0, 17));
      fwd_exmem = 16'($urandom); fwd_memwb = 16'($urandom);
      fwd1_sel = 2'($urandom_range(0, 3)); fwd2_sel = 2'($urandom_range(0, 3));
      alu_src = 2'($urandom_range(0, 3)); inport_en = 1'($urandom_range(0, 1));
      alu_op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(14, 31))
                                           : 5'($urandom_range(0, 13));
      branch = ($urandom_range(0, 3) == 0);
      jmp_cond = 2'($urandom_range(0, 3));
      if (branch && alu_op == 5'h0D) alu_op = 5'h02;
      if ($urandom_range(0, 9) == 0) begin
        in_valid = 1; flush = 1;
        tick();
        clear_inputs();
        chk("rnd_flush.valid", 32'(out_valid), 32'(0));
        chk("rnd_flush.br", 32'(br_taken), 32'(0));
        chk("rnd_flush.ccr", 32'(ccr), 32'(m_ccr));
      end else if (alu_op == 5'h0D) begin
        run_mul("rnd_mul");
      end else begin
        run_sc("rnd");
      end
    end

    // Asynchronous reset in the middle of a multiply.
    clear_inputs();
    op1 = 16'h00FF; op2 = 16'h00FF; alu_op = 5'h0D; in_valid = 1;
    tick();
    in_valid = 0;
    tick(); tick();
    #3;
    rst = 0;
    #1;
    m_result = '0; m_mem = '0; m_target = '0; m_ccr = '0;
    check_all_zero("rst_mul");
    #2;
    rst = 1;
    clear_inputs();
    op1 = 16'h0001; op2 = 16'h0001; alu_op = 5'h02;
    run_sc("post_rst_add");
    chk("post_rst_add.const", 32'(result), 32'(16'h0002));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
